// File: rtl/pop_gate_sequencer_if.sv
// pop_gate_sequencer_if: bundles the run enable, the state level from the
// sequence state machine and all gate/status outputs of the POP gate sequencer.
//
// There is no valid/ready handshake: state and enable are levels sampled on
// every rising clk edge, and every output is a registered level (cycle_done
// is a one-clk strobe) that is meaningful on every cycle.
interface pop_gate_sequencer_if #(
    parameter int SEQ_W = 16
) ();
    logic             enable;
    logic [1:0]       state;
    logic             laser_gate;
    logic             mw_gate;
    logic             mw_phase;
    logic             det_gate;
    logic             cycle_done;
    logic [SEQ_W-1:0] seq_count;
    logic             seq_error;

    // Upstream side: drives state and enable, observes the gates.
    modport master (
        output enable, state,
        input  laser_gate, mw_gate, mw_phase, det_gate, cycle_done, seq_count, seq_error
    );

    // Sequencer side.
    modport slave (
        input  enable, state,
        output laser_gate, mw_gate, mw_phase, det_gate, cycle_done, seq_count, seq_error
    );
endinterface

// File: rtl/pop_gate_sequencer.sv
// pop_gate_sequencer: turns the 2-bit POP sequence state into cycle-accurate
// laser, microwave (two Ramsey pulses) and detection gates, counts completed
// sequences and flags illegal state transitions.
// Optional feature macro: POP_MW_PHASE_TOGGLE_EN (phase select on Ramsey pulse 2,
// toggling once per completed sequence). Without it mw_phase is tied to 0.
module pop_gate_sequencer #(
    parameter int CNT_W    = 16,
    parameter int PUMP_LEN = 1000,
    parameter int MW_DLY   = 20,
    parameter int MW_LEN   = 50,
    parameter int T_RAMSEY = 500,
    parameter int DET_LEN  = 300,
    parameter int DET_DLY  = 10,
    parameter int DET_WIN  = 200,
    parameter int SEQ_W    = 16
) (
    input logic                  clk,
    input logic                  reset,
    pop_gate_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_PUMP   = 2'd0,
        ST_DARK   = 2'd1,
        ST_DETECT = 2'd2,
        ST_IDLE   = 2'd3
    } seq_state_t;

    // Window bounds are held two bits wider than the counter so that a bound
    // beyond the saturation value simply keeps the gate open until state changes.
    localparam int BW = CNT_W + 2;
    localparam logic [BW-1:0] PUMP_END = BW'(PUMP_LEN);
    localparam logic [BW-1:0] MW1_BEG  = BW'(MW_DLY);
    localparam logic [BW-1:0] MW1_END  = BW'(MW_DLY + MW_LEN);
    localparam logic [BW-1:0] MW2_BEG  = BW'(MW_DLY + MW_LEN + T_RAMSEY);
    localparam logic [BW-1:0] MW2_END  = BW'(MW_DLY + 2 * MW_LEN + T_RAMSEY);
    localparam logic [BW-1:0] DET_END  = BW'(DET_LEN);
    localparam logic [BW-1:0] DW_BEG   = BW'(DET_DLY);
    localparam logic [BW-1:0] DW_END   = BW'(DET_DLY + DET_WIN);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    seq_state_t       state_q;
    logic [CNT_W-1:0] cnt;
    logic             first_seen;
    logic             done_q;
    logic             illegal_q;
    logic             entry;
    logic             legal;
    logic [1:0]       state_raw;
    logic [1:0]       succ;
    logic [BW-1:0]    cnt_ext;
    logic             in_mw1;
    logic             in_mw2;

    logic             laser_d;
    logic             mw_d;
    logic             det_d;

    logic             laser_r;
    logic             mw_r;
    logic             det_r;
    logic             done_r;
    logic [SEQ_W-1:0] seq_r;
    logic             err_r;

    assign state_raw = state_q;
    assign succ      = state_raw + 2'd1;
    assign entry     = (bus.state != state_raw);
    assign legal     = (bus.state == succ);
    assign cnt_ext   = {2'b00, cnt};
    assign in_mw1    = (cnt_ext >= MW1_BEG) && (cnt_ext < MW1_END);
    assign in_mw2    = (cnt_ext >= MW2_BEG) && (cnt_ext < MW2_END);

    // Input register: track the state level, count cycles spent in it (saturating)
    // and pre-compute completion / illegal-entry events one cycle ahead of the gates.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            cnt        <= '0;
            first_seen <= 1'b0;
            done_q     <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            state_q   <= seq_state_t'(bus.state);
            done_q    <= entry && (state_q == ST_DETECT) && (bus.state == 2'd3);
            illegal_q <= entry && first_seen && !legal;
            if (entry) begin
                cnt        <= '0;
                first_seen <= 1'b1;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Gate decode from the registered state and the in-state cycle count.
    always_comb begin
        laser_d = 1'b0;
        mw_d    = 1'b0;
        det_d   = 1'b0;
        case (state_q)
            ST_PUMP:   laser_d = (cnt_ext < PUMP_END);
            ST_DARK:   mw_d    = in_mw1 || in_mw2;
            ST_DETECT: begin
                laser_d = (cnt_ext < DET_END);
                det_d   = (cnt_ext >= DW_BEG) && (cnt_ext < DW_END);
            end
            default:   ;
        endcase
    end

    // Output register: gates and completion strobe are masked by enable; the
    // error flag is sticky and keeps being evaluated while disabled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            laser_r <= 1'b0;
            mw_r    <= 1'b0;
            det_r   <= 1'b0;
            done_r  <= 1'b0;
            seq_r   <= '0;
            err_r   <= 1'b0;
        end else begin
            laser_r <= bus.enable && laser_d;
            mw_r    <= bus.enable && mw_d;
            det_r   <= bus.enable && det_d;
            done_r  <= bus.enable && done_q;
            err_r   <= err_r || illegal_q;
            if (bus.enable && done_q) begin
                seq_r <= seq_r + SEQ_W'(1);
            end
        end
    end

`ifdef POP_MW_PHASE_TOGGLE_EN
    logic phase;
    logic mw_phase_r;

    // Phase bit flips once per issued cycle_done; it is presented only while
    // the second Ramsey pulse is on, aligned with mw_gate.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase      <= 1'b0;
            mw_phase_r <= 1'b0;
        end else begin
            mw_phase_r <= bus.enable && (state_q == ST_DARK) && in_mw2 && phase;
            if (bus.enable && done_q) begin
                phase <= !phase;
            end
        end
    end

    assign bus.mw_phase = mw_phase_r;
`else
    assign bus.mw_phase = 1'b0;
`endif

    assign bus.laser_gate = laser_r;
    assign bus.mw_gate    = mw_r;
    assign bus.det_gate   = det_r;
    assign bus.cycle_done = done_r;
    assign bus.seq_count  = seq_r;
    assign bus.seq_error  = err_r;
endmodule

// File: tb/tb_pop_gate_sequencer.sv
// tb_pop_gate_sequencer: directed sequences against a cycle timeline of
// expected outputs; a negedge monitor pops and compares every cycle.
module tb_pop_gate_sequencer;
    localparam int N = 2048;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    pop_gate_sequencer_if #(.SEQ_W(4)) bus ();

    pop_gate_sequencer #(
        .CNT_W(4), .PUMP_LEN(10), .MW_DLY(2), .MW_LEN(3), .T_RAMSEY(5),
        .DET_LEN(8), .DET_DLY(1), .DET_WIN(4), .SEQ_W(4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int         st_arr [N];
    bit         en_arr [N];
    int         run_start [N];
    bit         done_ev [N+2];
    bit         err_ev [N+2];
    logic [9:0] exp_vec [N];
    int         len_t;

    logic [9:0] exp_q [$];
    int         n_cmp;
    int         n_fail;
    bit         mon_en;

    // Vector layout: laser, mw, mw_phase, det, cycle_done, seq_error, seq_count[3:0]
    function automatic logic [9:0] dut_vec();
        return {bus.laser_gate, bus.mw_gate, bus.mw_phase, bus.det_gate,
                bus.cycle_done, bus.seq_error, bus.seq_count};
    endfunction

    task automatic add_seg(input int s, input int n);
        for (int i = 0; i < n; i++) begin
            st_arr[len_t] = s;
            en_arr[len_t] = 1'b1;
            len_t++;
        end
    endtask

    task automatic en_low(input int a, input int b);
        for (int i = a; i <= b; i++) en_arr[i] = 1'b0;
    endtask

    // Timeline of expectations: inputs driven in cycle t reach the gates in
    // cycle t+2; enable in cycle u-1 masks the gates of cycle u.
    task automatic build_expected();
        int p;
        bit fs;
        int seqc;
        int ndone;
        bit err;
        fs = 0; seqc = 0; ndone = 0; err = 0;
        for (int t = 0; t < len_t; t++) begin
            p = (t == 0) ? 3 : st_arr[t-1];
            if (st_arr[t] != p) begin
                run_start[t] = t;
                if (fs && (((p + 1) % 4) != st_arr[t])) err_ev[t+2] = 1'b1;
                fs = 1;
                if (p == 2 && st_arr[t] == 3 && (t + 1 >= len_t || en_arr[t+1]))
                    done_ev[t+2] = 1'b1;
            end else begin
                run_start[t] = (t == 0) ? 0 : run_start[t-1];
            end
        end
        for (int u = 0; u < len_t; u++) begin
            bit l, m, m2, d, ph, ph_o;
            int s, c;
            logic [3:0] sc4;
            l = 0; m = 0; m2 = 0; d = 0;
            ph = ndone[0];
            if (done_ev[u]) begin
                seqc = (seqc + 1) % 16;
                ndone++;
            end
            err = err | err_ev[u];
            if (u >= 2 && en_arr[u-1]) begin
                s = st_arr[u-2];
                c = u - 2 - run_start[u-2];
                if (c > 15) c = 15;
                case (s)
                    0: l = (c < 10);
                    1: begin
                        m2 = (c >= 10 && c < 13);
                        m  = (c >= 2 && c < 5) || m2;
                    end
                    2: begin
                        l = (c < 8);
                        d = (c >= 1 && c < 5);
                    end
                    default: ;
                endcase
            end
`ifdef POP_MW_PHASE_TOGGLE_EN
            ph_o = m2 && ph;
`else
            ph_o = 1'b0;
`endif
            sc4 = seqc[3:0];
            exp_vec[u] = {l, m, ph_o, d, done_ev[u], err, sc4};
        end
    endtask

    task automatic chk(input string name, input logic [9:0] got, input logic [9:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%b exp=%b at %0t", name, got, exp, $time);
        end
    endtask

    // Monitor: one comparison per cycle while the timeline run is active.
    always @(negedge clk) begin
        if (mon_en && exp_q.size() > 0) begin
            logic [9:0] e;
            e = exp_q.pop_front();
            n_cmp++;
            if (dut_vec() !== e) begin
                n_fail++;
                $display("FAIL outputs got=%b exp=%b at %0t", dut_vec(), e, $time);
            end
        end
    end

    initial begin
        int t1, t3;
        n_cmp = 0; n_fail = 0; mon_en = 1'b0; len_t = 0;
        reset = 1'b0;
        bus.state = 2'd3;
        bus.enable = 1'b1;

        // Stimulus program
        add_seg(3, 5);
        // nominal sequence, 40 clk per state (counter saturates at 15)
        add_seg(0, 40); add_seg(1, 40); add_seg(2, 40); add_seg(3, 40);
        // truncated pump
        add_seg(0, 6); add_seg(1, 20); add_seg(2, 20); add_seg(3, 20);
        // enable dropped over pulse 1 and over the 2->3 entry
        add_seg(0, 15);
        t1 = len_t;
        add_seg(1, 30);
        add_seg(2, 15);
        t3 = len_t;
        add_seg(3, 10);
        en_low(t1 + 3, t1 + 8);
        en_low(t3 - 3, t3 + 4);
        // illegal 1->3, then a legal sequence
        add_seg(0, 15); add_seg(1, 15); add_seg(3, 15);
        add_seg(0, 20); add_seg(1, 20); add_seg(2, 20); add_seg(3, 20);
        // 14 more sequences: 17 completions in total, seq_count wraps to 1
        for (int k = 0; k < 14; k++) begin
            add_seg(0, 12); add_seg(1, 16); add_seg(2, 8); add_seg(3, 4);
        end
        build_expected();

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_outputs", dut_vec(), 10'b0);
        reset = 1'b1;
        mon_en = 1'b1;

        for (int k = 0; k < len_t; k++) begin
            @(posedge clk);
            #1;
            bus.state  = st_arr[k][1:0];
            bus.enable = en_arr[k];
            exp_q.push_back(exp_vec[k]);
        end
        @(negedge clk);
        #1;
        mon_en = 1'b0;
        chk("queue_drained", 10'(exp_q.size()), 10'd0);
        chk("final_seq_count", {6'b0, bus.seq_count}, 10'd1);
        chk("final_seq_error", {9'b0, bus.seq_error}, 10'd1);

        // Async reset in the middle of det_gate
        @(posedge clk); #1; bus.state = 2'd0;
        repeat (12) @(posedge clk); #1; bus.state = 2'd1;
        repeat (16) @(posedge clk); #1; bus.state = 2'd2;
        repeat (4) @(posedge clk); #1;
        chk("det_before_reset", {9'b0, bus.det_gate}, 10'd1);
        #2 reset = 1'b0;
        #1;
        chk("async_reset_outputs", dut_vec(), 10'b0);
        @(negedge clk);
        reset = 1'b1;
        // first entry after reset (3->2) must not flag an error
        repeat (2) @(negedge clk);
        chk("laser_after_reset", {9'b0, bus.laser_gate}, 10'd1);
        repeat (2) @(negedge clk);
        chk("first_entry_legal", {9'b0, bus.seq_error}, 10'd0);
        // a later 2->0 entry is illegal
        bus.state = 2'd0;
        repeat (3) @(negedge clk);
        chk("illegal_after_reset", {9'b0, bus.seq_error}, 10'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
